fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of the async FIFO write side among NUM_REQ requesters.
- Drives winc/wdata into the FIFO write domain and back-pressures on wfull.
- A grant is held for a whole packet (until req_last) or for MAX_BURST beats, whichever comes first. This keeps packets contiguous in the FIFO while still bounding starvation.

---
 rtl/fifo_wr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the async FIFO write port
// among NUM_REQ requesters. A grant is held for a whole packet (until
// req_last) or for MAX_BURST beats, whichever comes first. Writes are held
// off while wfull is high.
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN. When it is defined, the
// module gains the stall_cnt output, a saturating count of stalled cycles.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state_r, state_n;
  logic [NUM_REQ-1:0]      grant_n;
  logic                    busy_n;
  logic [PTR_W-1:0]        owner_r, owner_n;
  logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_n;
  logic [CNT_WIDTH-1:0]    beat_cnt_r, beat_cnt_n;
  logic [PTR_W-1:0]        win_idx_s;
  logic                    win_found_s;
  logic [PTR_W:0]          cand_s;
  logic                    sel_valid_s;
  logic                    sel_last_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    in_grant_s;
  logic                    accept_s;
  logic                    done_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (cand_s >= (PTR_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req_valid[cand_s[PTR_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the current owner's valid/last/data lanes.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_r == PTR_W'(i)) begin
        sel_valid_s = req_valid[i];
        sel_last_s  = req_last[i];
        sel_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Write-port handshake; combinational so a beat can land every cycle.
  always_comb begin
    in_grant_s = (state_r == GRANT);
    accept_s   = in_grant_s & sel_valid_s & ~wfull;
    done_s     = accept_s & (sel_last_s | (beat_cnt_r == CNT_WIDTH'(MAX_BURST - 1)));
    winc       = accept_s;
    if (in_grant_s) begin
      wdata     = sel_data_s;
      req_ready = wfull ? '0 : grant;
    end else begin
      wdata     = '0;
      req_ready = '0;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_n    = state_r;
    grant_n    = grant;
    owner_n    = owner_r;
    rr_ptr_n   = rr_ptr_r;
    beat_cnt_n = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_n    = GRANT;
          grant_n    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
          owner_n    = win_idx_s;
          beat_cnt_n = '0;
          rr_ptr_n   = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (done_s) begin
          // Last beat or burst cap: release, forcing one idle bubble.
          state_n    = IDLE;
          grant_n    = '0;
          beat_cnt_n = '0;
        end else if (accept_s) begin
          beat_cnt_n = beat_cnt_r + CNT_WIDTH'(1);
        end else begin
          // Stalled or owner idle mid-packet: hold the grant.
          beat_cnt_n = beat_cnt_r;
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        beat_cnt_n = '0;
      end
    endcase
    busy_n = (state_n == GRANT);
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      grant      <= grant_n;
      busy       <= busy_n;
      owner_r    <= owner_n;
      rr_ptr_r   <= rr_ptr_n;
      beat_cnt_r <= beat_cnt_n;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  // Saturating count of cycles where the owner had a beat but wfull blocked it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (in_grant_s && sel_valid_s && wfull && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_viol   = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for a write strobe while the FIFO reports full.
  always @(negedge clk) begin
    if (winc === 1'b1 && wfull === 1'b1) n_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i]        = v;
    req_last[i]         = l;
    req_data[i*8 +: 8]  = d;
  endtask

  task automatic clr_all();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0000_0000;
  endtask

  // Check the usual per-beat outputs in one call.
  task automatic chk_beat(input string tag, input logic [3:0] g, input logic w, input logic [7:0] d);
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, "_winc"},  {31'd0, winc},  {31'd0, w});
    if (w) chk({tag, "_wdata"}, {24'd0, wdata}, {24'd0, d});
  endtask

  initial begin
    logic [3:0] rr_order [5];
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;

    // 1. Reset with random inputs.
    rst = 1'b1;
    req_valid = 4'($urandom);
    req_last  = 4'($urandom);
    req_data  = $urandom;
    wfull     = 1'($urandom);
    #2;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    tick(); tick();
    clr_all();
    wfull = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("idle_grant", {28'd0, grant}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif

    // 2. Single 3-beat packet from requester 2.
    set_req(2, 1'b1, 1'b0, 8'hA0);
    settle();
    chk_beat("t2_req", 4'b0000, 1'b0, 8'h00);
    tick();
    chk_beat("t2_b0", 4'b0100, 1'b1, 8'hA0);
    chk("t2_ready", {28'd0, req_ready}, 32'h4);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick();
    set_req(2, 1'b1, 1'b0, 8'hA1);
    settle();
    chk_beat("t2_b1", 4'b0100, 1'b1, 8'hA1);
    tick();
    set_req(2, 1'b1, 1'b1, 8'hA2);
    settle();
    chk_beat("t2_b2", 4'b0100, 1'b1, 8'hA2);
    tick();
    clr_all();
    settle();
    chk_beat("t2_end", 4'b0000, 1'b0, 8'h00);
    chk("t2_end_busy", {31'd0, busy}, 32'd0);

    // Reset so the pointer starts at requester 0 again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 3. Round-robin with 1-beat packets from everyone.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'h10 + 8'(i));
    settle();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_beat($sformatf("t3_g%0d", n), rr_order[n], 1'b1,
               (rr_order[n] == 4'b0001) ? 8'h10 : (rr_order[n] == 4'b0010) ? 8'h11 :
               (rr_order[n] == 4'b0100) ? 8'h12 : 8'h13);
      tick();
      chk($sformatf("t3_bubble%0d", n), {28'd0, grant}, 32'd0);
    end
    clr_all();
    tick();

    // 4. Burst cap: 6-beat packet from requester 1 splits 4 + 2.
    set_req(1, 1'b1, 1'b0, 8'h60);
    settle();
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat($sformatf("t4_b%0d", b), 4'b0010, 1'b1, 8'h60 + 8'(b));
      tick();
      set_req(1, 1'b1, 1'b0, 8'h61 + 8'(b));
      settle();
    end
    chk_beat("t4_cap", 4'b0000, 1'b0, 8'h00);
    chk("t4_cap_busy", {31'd0, busy}, 32'd0);
    tick();
    chk_beat("t4_b4", 4'b0010, 1'b1, 8'h64);
    tick();
    set_req(1, 1'b1, 1'b1, 8'h65);
    settle();
    chk_beat("t4_b5", 4'b0010, 1'b1, 8'h65);
    tick();
    clr_all();
    settle();
    chk_beat("t4_end", 4'b0000, 1'b0, 8'h00);
    tick();

    // 5. Backpressure for 3 cycles mid-packet of requester 0.
    set_req(0, 1'b1, 1'b0, 8'h50);
    settle();
    tick();
    chk_beat("t5_b0", 4'b0001, 1'b1, 8'h50);
    tick();
    set_req(0, 1'b1, 1'b0, 8'h51);
    settle();
    chk_beat("t5_b1", 4'b0001, 1'b1, 8'h51);
    tick();
    set_req(0, 1'b1, 1'b0, 8'h52);
    wfull = 1'b1;
    settle();
    for (int s = 0; s < 3; s++) begin
      chk_beat($sformatf("t5_stall%0d", s), 4'b0001, 1'b0, 8'h00);
      chk($sformatf("t5_ready%0d", s), {28'd0, req_ready}, 32'd0);
      tick();
    end
    wfull = 1'b0;
    settle();
    chk_beat("t5_b2", 4'b0001, 1'b1, 8'h52);
    tick();
    set_req(0, 1'b1, 1'b1, 8'h53);
    settle();
    chk_beat("t5_b3", 4'b0001, 1'b1, 8'h53);
    tick();
    clr_all();
    settle();
    chk_beat("t5_end", 4'b0000, 1'b0, 8'h00);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    chk("t5_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif
    tick();

    // 6. Reset mid-packet, then pointer must be back at requester 0.
    set_req(2, 1'b1, 1'b0, 8'hC0);
    settle();
    tick();
    chk_beat("t6_b0", 4'b0100, 1'b1, 8'hC0);
    tick();
    set_req(2, 1'b1, 1'b0, 8'hC1);
    settle();
    chk_beat("t6_b1", 4'b0100, 1'b1, 8'hC1);
    tick();
    set_req(2, 1'b1, 1'b0, 8'hC2);
    rst = 1'b1;
    settle();
    chk_beat("t6_rst", 4'b0000, 1'b0, 8'h00);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    clr_all();
    set_req(3, 1'b1, 1'b1, 8'hD3);
    set_req(0, 1'b1, 1'b1, 8'hD0);
    settle();
    tick();
    chk_beat("t6_prio", 4'b0001, 1'b1, 8'hD0);
    tick();
    tick();
    chk_beat("t6_next", 4'b1000, 1'b1, 8'hD3);
    clr_all();
    tick();

    chk("no_winc_when_full", n_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
